ktc_test_mmio: RTL and testbench

//  Memory-mapped test/console port between the ktc16 core's data-write bus and the ram.
//  - Decodes core stores: console writes go into a TX byte FIFO; result writes end the test

---
 rtl/ktc_mmio_pkg.sv | 9 +
 rtl/ktc_sync_fifo.sv | 57 +++++
 rtl/ktc_test_mmio.sv | 99 +++++++++
 tb/tb_ktc_test_mmio.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ktc_mmio_pkg.sv
// rtl/ktc_mmio_pkg.sv - shared state type and default decode addresses for the ktc16 test MMIO port
package ktc_mmio_pkg;

   typedef enum logic [1:0] {RUN, PASS, FAIL, TIMEOUT} test_state_t;

   localparam logic [31:0] CONSOLE_ADDR = 32'd80;
   localparam logic [31:0] RESULT_ADDR  = 32'd84;

endpackage

// File: rtl/ktc_sync_fifo.sv
// rtl/ktc_sync_fifo.sv - single-clock FIFO with a registered head byte (0 when empty)
module ktc_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr, rd_ptr, wr_nxt, rd_nxt;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] head_nxt;
   logic             do_pop;

   assign empty  = (wr_ptr == rd_ptr);
   assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop = pop & ~empty;
   assign wr_nxt = wr_ptr + {{AW{1'b0}}, push};
   assign rd_nxt = rd_ptr + {{AW{1'b0}}, do_pop};

   // The next head is the incoming byte when it lands in the slot the read pointer moves to.
   always_comb begin
      head_nxt = '0;
      if (wr_nxt != rd_nxt) begin
         if (push && (rd_nxt[AW-1:0] == wr_ptr[AW-1:0]))
            head_nxt = din;
         else
            head_nxt = mem[rd_nxt[AW-1:0]];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         head   <= '0;
      end else begin
         wr_ptr <= wr_nxt;
         rd_ptr <= rd_nxt;
         head   <= head_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/ktc_test_mmio.sv
// rtl/ktc_test_mmio.sv - ktc16 store decoder: console FIFO, pass/fail result port, watchdog, ram gating
module ktc_test_mmio #(
   parameter logic [31:0] CONSOLE_ADDR   = ktc_mmio_pkg::CONSOLE_ADDR,
   parameter logic [31:0] RESULT_ADDR    = ktc_mmio_pkg::RESULT_ADDR,
   parameter logic [31:0] PASS_VALUE     = 32'd7,
   parameter int          FIFO_DEPTH     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter logic        STRICT         = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] addr,
   input  logic [31:0] wd,
   output logic        ram_we,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        done,
   output logic        pass,
   output logic        timeout,
   output logic        overflow,
   output logic [31:0] fail_code,
   output logic [31:0] cycle_cnt
);

   import ktc_mmio_pkg::*;

   test_state_t state, state_nxt;
   logic [31:0] fail_code_nxt;
   logic        running, is_console, is_result;
   logic        console_st, pop, push, drop, full, empty;

   assign running    = (state == RUN);
   assign is_console = (addr == CONSOLE_ADDR);
   assign is_result  = (addr == RESULT_ADDR);
   assign console_st = memwrite & running & is_console;
   assign pop        = tx_valid & tx_ready;
   // A full FIFO still takes the byte when the consumer frees a slot in the same cycle.
   assign push       = console_st & (~full | pop);
   assign drop       = console_st & full & ~pop;

   assign ram_we   = memwrite & running & ~is_console & ~is_result & ~STRICT;
   assign tx_valid = ~empty;
   assign done     = (state != RUN);
   assign pass     = (state == PASS);
   assign timeout  = (state == TIMEOUT);

   ktc_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (wd[7:0]),
      .full  (full),
      .empty (empty),
      .head  (tx_data)
   );

   always_comb begin
      state_nxt     = state;
      fail_code_nxt = fail_code;
      if (running) begin
         if (memwrite && is_result) begin
            if (wd == PASS_VALUE) begin
               state_nxt = PASS;
            end else begin
               state_nxt     = FAIL;
               fail_code_nxt = wd;
            end
         end else if (STRICT && memwrite && !is_console) begin
            state_nxt     = FAIL;
            fail_code_nxt = addr;
         end else if ((TIMEOUT_CYCLES != 0) && !memwrite && (cycle_cnt == TIMEOUT_CYCLES - 1)) begin
            state_nxt = TIMEOUT;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= RUN;
         fail_code <= '0;
         cycle_cnt <= '0;
         overflow  <= 1'b0;
      end else begin
         state     <= state_nxt;
         fail_code <= fail_code_nxt;
         if (running && (cycle_cnt != 32'hFFFF_FFFF))
            cycle_cnt <= cycle_cnt + 32'd1;
         if (drop)
            overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ktc_test_mmio.sv
// tb/tb_ktc_test_mmio.sv - directed bench for ktc_test_mmio (default, short-watchdog and strict instances)
module tb_ktc_test_mmio;

   logic        clk = 1'b0, reset = 1'b0, memwrite = 1'b0, tx_ready = 1'b0;
   logic [31:0] addr = '0, wd = '0;
   int          total = 0, bad = 0;

   logic        m_ram_we, m_tx_valid, m_done, m_pass, m_timeout, m_overflow;
   logic [7:0]  m_tx_data;
   logic [31:0] m_fail_code, m_cycle_cnt;
   logic        t_ram_we, t_tx_valid, t_done, t_pass, t_timeout, t_overflow;
   logic [7:0]  t_tx_data;
   logic [31:0] t_fail_code, t_cycle_cnt;
   logic        s_ram_we, s_tx_valid, s_done, s_pass, s_timeout, s_overflow;
   logic [7:0]  s_tx_data;
   logic [31:0] s_fail_code, s_cycle_cnt;

   always #5 clk = ~clk;

   ktc_test_mmio #(.FIFO_DEPTH(8)) u_main (
      .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr), .wd(wd),
      .ram_we(m_ram_we), .tx_valid(m_tx_valid), .tx_data(m_tx_data), .tx_ready(tx_ready),
      .done(m_done), .pass(m_pass), .timeout(m_timeout), .overflow(m_overflow),
      .fail_code(m_fail_code), .cycle_cnt(m_cycle_cnt));

   ktc_test_mmio #(.TIMEOUT_CYCLES(20)) u_to (
      .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr), .wd(wd),
      .ram_we(t_ram_we), .tx_valid(t_tx_valid), .tx_data(t_tx_data), .tx_ready(tx_ready),
      .done(t_done), .pass(t_pass), .timeout(t_timeout), .overflow(t_overflow),
      .fail_code(t_fail_code), .cycle_cnt(t_cycle_cnt));

   ktc_test_mmio #(.STRICT(1'b1), .TIMEOUT_CYCLES(0)) u_strict (
      .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr), .wd(wd),
      .ram_we(s_ram_we), .tx_valid(s_tx_valid), .tx_data(s_tx_data), .tx_ready(tx_ready),
      .done(s_done), .pass(s_pass), .timeout(s_timeout), .overflow(s_overflow),
      .fail_code(s_fail_code), .cycle_cnt(s_cycle_cnt));

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      cyc();
      cyc();
      reset = 1'b1;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      memwrite = 1'b1; addr = a; wd = d;
      cyc();
      memwrite = 1'b0; addr = '0; wd = '0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #1;
      total++; if ({m_done, m_pass, m_timeout, m_overflow, m_tx_valid} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=00000", {m_done, m_pass, m_timeout, m_overflow, m_tx_valid}); end
      total++; if ({m_tx_data, m_fail_code, m_cycle_cnt} !== 72'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", {m_tx_data, m_fail_code, m_cycle_cnt}); end
      cyc();
      cyc();
      total++; if (m_cycle_cnt !== 32'd0) begin bad++; $display("FAIL reset_hold_cnt got=%0d exp=0", m_cycle_cnt); end
      reset = 1'b1;
   endtask

   task automatic test_pass();
      do_reset();
      repeat (4) cyc();
      memwrite = 1'b1; addr = 32'd84; wd = 32'd7;
      #1;
      total++; if (m_ram_we !== 1'b0) begin bad++; $display("FAIL pass_ram_we got=%b exp=0", m_ram_we); end
      total++; if (m_done !== 1'b0) begin bad++; $display("FAIL pass_pre_done got=%b exp=0", m_done); end
      cyc();
      memwrite = 1'b0; addr = '0; wd = '0;
      total++; if ({m_done, m_pass, m_timeout} !== 3'b110) begin bad++; $display("FAIL pass_flags got=%b exp=110", {m_done, m_pass, m_timeout}); end
      total++; if (m_cycle_cnt !== 32'd5) begin bad++; $display("FAIL pass_cnt got=%0d exp=5", m_cycle_cnt); end
      memwrite = 1'b1; addr = 32'h100; wd = 32'h5;
      #1;
      total++; if (m_ram_we !== 1'b0) begin bad++; $display("FAIL pass_term_ram_we got=%b exp=0", m_ram_we); end
      cyc();
      memwrite = 1'b0; addr = '0; wd = '0;
      total++; if (m_cycle_cnt !== 32'd5) begin bad++; $display("FAIL pass_cnt_frozen got=%0d exp=5", m_cycle_cnt); end
   endtask

   task automatic test_fail();
      do_reset();
      store(32'd84, 32'd3);
      total++; if ({m_done, m_pass} !== 2'b10) begin bad++; $display("FAIL fail_flags got=%b exp=10", {m_done, m_pass}); end
      total++; if (m_fail_code !== 32'd3) begin bad++; $display("FAIL fail_code got=%h exp=3", m_fail_code); end
      total++; if (m_cycle_cnt !== 32'd1) begin bad++; $display("FAIL fail_cnt got=%0d exp=1", m_cycle_cnt); end
      cyc();
      store(32'd84, 32'd7);
      total++; if ({m_done, m_pass, m_fail_code} !== {2'b10, 32'd3}) begin bad++; $display("FAIL fail_sticky got=%b/%h exp=10/3", {m_done, m_pass}, m_fail_code); end
      total++; if (m_cycle_cnt !== 32'd1) begin bad++; $display("FAIL fail_cnt_frozen got=%0d exp=1", m_cycle_cnt); end
   endtask

   task automatic test_console();
      do_reset();
      tx_ready = 1'b0;
      memwrite = 1'b1; addr = 32'd80; wd = 32'h0000_0148;
      #1;
      total++; if (m_ram_we !== 1'b0) begin bad++; $display("FAIL con_ram_we got=%b exp=0", m_ram_we); end
      total++; if (m_tx_valid !== 1'b0) begin bad++; $display("FAIL con_pre_valid got=%b exp=0", m_tx_valid); end
      cyc();
      memwrite = 1'b0;
      total++; if ({m_tx_valid, m_tx_data} !== {1'b1, 8'h48}) begin bad++; $display("FAIL con_first got=%b/%h exp=1/48", m_tx_valid, m_tx_data); end
      store(32'd80, 32'h69);
      total++; if (m_tx_data !== 8'h48) begin bad++; $display("FAIL con_head_hold got=%h exp=48", m_tx_data); end
      tx_ready = 1'b1;
      cyc();
      total++; if ({m_tx_valid, m_tx_data} !== {1'b1, 8'h69}) begin bad++; $display("FAIL con_second got=%b/%h exp=1/69", m_tx_valid, m_tx_data); end
      cyc();
      total++; if ({m_tx_valid, m_tx_data} !== {1'b0, 8'h00}) begin bad++; $display("FAIL con_empty got=%b/%h exp=0/00", m_tx_valid, m_tx_data); end
      tx_ready = 1'b0;
   endtask

   task automatic test_overflow();
      do_reset();
      tx_ready = 1'b0;
      for (int i = 1; i <= 8; i++) store(32'd80, 32'(i));
      total++; if ({m_overflow, m_tx_data} !== {1'b0, 8'h01}) begin bad++; $display("FAIL ovf_fill got=%b/%h exp=0/01", m_overflow, m_tx_data); end
      store(32'd80, 32'd9);
      total++; if (m_overflow !== 1'b1) begin bad++; $display("FAIL ovf_drop got=%b exp=1", m_overflow); end
      tx_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         total++; if (m_tx_data !== 8'(i)) begin bad++; $display("FAIL ovf_drain[%0d] got=%h exp=%h", i, m_tx_data, 8'(i)); end
         cyc();
      end
      total++; if (m_tx_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%b exp=0", m_tx_valid); end
      tx_ready = 1'b0;

      do_reset();
      for (int i = 1; i <= 8; i++) store(32'd80, 32'(i));
      tx_ready = 1'b1;
      store(32'd80, 32'hAA);
      total++; if ({m_overflow, m_tx_data} !== {1'b0, 8'h02}) begin bad++; $display("FAIL ovf_pushpop got=%b/%h exp=0/02", m_overflow, m_tx_data); end
      for (int i = 2; i <= 8; i++) begin
         total++; if (m_tx_data !== 8'(i)) begin bad++; $display("FAIL ovf_keep[%0d] got=%h exp=%h", i, m_tx_data, 8'(i)); end
         cyc();
      end
      total++; if ({m_tx_valid, m_tx_data} !== {1'b1, 8'hAA}) begin bad++; $display("FAIL ovf_kept_byte got=%b/%h exp=1/aa", m_tx_valid, m_tx_data); end
      cyc();
      total++; if (m_tx_valid !== 1'b0) begin bad++; $display("FAIL ovf_final_empty got=%b exp=0", m_tx_valid); end
      tx_ready = 1'b0;
   endtask

   task automatic test_timeout();
      do_reset();
      repeat (19) cyc();
      total++; if ({t_timeout, t_cycle_cnt} !== {1'b0, 32'd19}) begin bad++; $display("FAIL to_before got=%b/%0d exp=0/19", t_timeout, t_cycle_cnt); end
      cyc();
      total++; if ({t_done, t_pass, t_timeout} !== 3'b101) begin bad++; $display("FAIL to_flags got=%b exp=101", {t_done, t_pass, t_timeout}); end
      total++; if (t_cycle_cnt !== 32'd20) begin bad++; $display("FAIL to_cnt got=%0d exp=20", t_cycle_cnt); end
      repeat (3) cyc();
      total++; if (t_cycle_cnt !== 32'd20) begin bad++; $display("FAIL to_cnt_frozen got=%0d exp=20", t_cycle_cnt); end

      do_reset();
      repeat (19) cyc();
      store(32'd84, 32'd7);
      total++; if ({t_done, t_pass, t_timeout} !== 3'b110) begin bad++; $display("FAIL to_result_wins got=%b exp=110", {t_done, t_pass, t_timeout}); end
   endtask

   task automatic test_strict();
      do_reset();
      memwrite = 1'b1; addr = 32'h100; wd = 32'h1234;
      #1;
      total++; if (m_ram_we !== 1'b1) begin bad++; $display("FAIL strict0_ram_we got=%b exp=1", m_ram_we); end
      total++; if (s_ram_we !== 1'b0) begin bad++; $display("FAIL strict1_ram_we got=%b exp=0", s_ram_we); end
      cyc();
      memwrite = 1'b0; addr = '0; wd = '0;
      total++; if ({s_done, s_pass, s_fail_code} !== {2'b10, 32'h100}) begin bad++; $display("FAIL strict1_fail got=%b/%h exp=10/100", {s_done, s_pass}, s_fail_code); end
      total++; if (m_done !== 1'b0) begin bad++; $display("FAIL strict0_running got=%b exp=0", m_done); end
   endtask

   task automatic test_async_reset();
      do_reset();
      tx_ready = 1'b0;
      store(32'd80, 32'h11);
      store(32'd80, 32'h22);
      store(32'd80, 32'h33);
      store(32'd84, 32'd3);
      tx_ready = 1'b1;
      cyc();
      total++; if ({m_done, m_tx_valid, m_tx_data} !== {2'b11, 8'h22}) begin bad++; $display("FAIL ar_draining got=%b/%h exp=11/22", {m_done, m_tx_valid}, m_tx_data); end
      #2 reset = 1'b0;
      #1;
      total++; if ({m_done, m_pass, m_timeout, m_overflow, m_tx_valid} !== 5'b0) begin bad++; $display("FAIL ar_flags got=%b exp=00000", {m_done, m_pass, m_timeout, m_overflow, m_tx_valid}); end
      total++; if ({m_tx_data, m_fail_code, m_cycle_cnt} !== 72'h0) begin bad++; $display("FAIL ar_data got=%h exp=0", {m_tx_data, m_fail_code, m_cycle_cnt}); end
      tx_ready = 1'b0;
      cyc();
      reset = 1'b1;
      cyc();
   endtask

   initial begin
      test_reset();
      test_pass();
      test_fail();
      test_console();
      test_overflow();
      test_timeout();
      test_strict();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL sim_time_limit got=expired exp=finished");
      $fatal(1, "time limit");
   end

endmodule
